// File: rtl/palette_pkg.sv
// Shared palette definitions used by the palette lookup reader and the palette RAM wrapper.
`timescale 1ns/1ps
package palette_pkg;
    localparam int BITS_PER_BYTE        = 8;
    localparam int PALETTE_ADDR_WIDTH   = 10;
    localparam int DEFAULT_NUM_CHANNELS = 3;

    function automatic int rgb_width(input int num_channels);
        return num_channels * BITS_PER_BYTE;
    endfunction

    typedef logic [DEFAULT_NUM_CHANNELS*BITS_PER_BYTE-1:0] rgb_word_t;
endpackage

// File: rtl/palette_lookup_fifo.sv
// Synchronous FIFO with a registered head word, occupancy count and synchronous active-low clear.
`timescale 1ns/1ps
module palette_lookup_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic             do_pop;
    logic             do_push;

    // Explicit wrap keeps the pointers correct for non-power-of-2 depths.
    assign rd_ptr_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
    assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // The next head is either already in storage or is the word arriving now.
            if (do_pop && (count > CNT_W'(1))) begin
                head <= mem[rd_ptr_inc];
            end else if (do_push && ((count == '0) || (do_pop && (count == CNT_W'(1))))) begin
                head <= push_data;
            end
        end
    end
endmodule

// File: rtl/palette_lookup.sv
// Palette port B reader: index stream in, packed RGB stream out, credit-based FIFO back-pressure.
// Optional transparency flag output enabled by defining PALETTE_LOOKUP_TRANSPARENCY_EN.
`timescale 1ns/1ps
module palette_lookup
    import palette_pkg::*;
#(
    parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
    parameter int FIFO_DEPTH   = 4
`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
    ,
    parameter logic [PALETTE_ADDR_WIDTH-1:0] TRANSPARENT_INDEX = '0
`endif
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    input  logic [PALETTE_ADDR_WIDTH-1:0]         pix_index,
    output logic                                  pal_rd,
    output logic [PALETTE_ADDR_WIDTH-1:0]         pal_addr,
    input  logic [NUM_CHANNELS*BITS_PER_BYTE-1:0] pal_data,
    output logic                                  rgb_valid,
    input  logic                                  rgb_ready,
    output logic [NUM_CHANNELS*BITS_PER_BYTE-1:0] rgb_data
`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
    ,
    output logic                                  rgb_transparent
`endif
);
    localparam int DATA_W = rgb_width(NUM_CHANNELS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
    localparam int FIFO_W = DATA_W + 1;
`else
    localparam int FIFO_W = DATA_W;
`endif

    logic              inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credits;
    logic              accept;
    logic              pop;
    logic [FIFO_W-1:0] fifo_in;
    logic [FIFO_W-1:0] fifo_head;

    // Credits cover queued words plus the read whose data is still coming back from the RAM.
    assign credits   = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign pix_ready = reset_n && (credits < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept    = pix_valid && pix_ready;
    assign pal_rd    = accept;
    assign pal_addr  = pix_index;
    assign rgb_valid = reset_n && (fifo_count != '0);
    assign pop       = rgb_valid && rgb_ready;
    assign rgb_data  = fifo_head[DATA_W-1:0];

`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
    logic transparent_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight      <= 1'b0;
            transparent_q <= 1'b0;
        end else begin
            inflight      <= accept;
            transparent_q <= (pix_index == TRANSPARENT_INDEX);
        end
    end

    assign fifo_in         = {transparent_q, pal_data};
    assign rgb_transparent = fifo_head[DATA_W];
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
        end
    end

    assign fifo_in = pal_data;
`endif

    palette_lookup_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_palette_lookup.sv
// Scoreboard bench for palette_lookup with a 1-cycle-latency palette RAM model.
`timescale 1ns/1ps
module tb_palette_lookup;
    import palette_pkg::*;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic              tr;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic              pix_valid;
    logic              pix_ready;
    logic [9:0]        pix_index;
    logic              pal_rd;
    logic [9:0]        pal_addr;
    logic [DATA_W-1:0] pal_data;
    logic              rgb_valid;
    logic              rgb_ready;
    logic [DATA_W-1:0] rgb_data;
    logic              rgb_transparent;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    palette_lookup dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_index (pix_index),
        .pal_rd    (pal_rd),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .rgb_valid (rgb_valid),
        .rgb_ready (rgb_ready),
        .rgb_data  (rgb_data)
`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
        ,
        .rgb_transparent (rgb_transparent)
`endif
    );

`ifndef PALETTE_LOOKUP_TRANSPARENCY_EN
    assign rgb_transparent = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] entry(input logic [9:0] n);
        logic [9:0] a;
        logic [9:0] b;
        a = n + 10'd1;
        b = n + 10'd2;
        return {n[7:0], a[7:0], b[7:0]};
    endfunction

    function automatic exp_t model(input logic [9:0] n);
        exp_t e;
        e.word = entry(n);
`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
        e.tr = (n == 10'd0);
`else
        e.tr = 1'b0;
`endif
        return e;
    endfunction

    // RAM returns garbage on cycles without a read so stray captures show up.
    always @(posedge clk) begin
        if (pal_rd) pal_data <= entry(pal_addr);
        else        pal_data <= DATA_W'($urandom);
    end

    task automatic tick(output logic acc, output logic popped, output exp_t obs, output int outst);
        @(negedge clk);
        acc       = pix_valid && pix_ready;
        popped    = rgb_valid && rgb_ready;
        obs.word  = rgb_data;
        obs.tr    = rgb_transparent;
        outst     = exp_q.size();
        if (acc) exp_q.push_back(model(pix_index));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pix_valid = 1'b1; pix_index = 10'd7; rgb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (pix_ready !== 1'b0) $display("[TB] FAIL reset_pix_ready: got %b expected 0", pix_ready); else passes++;
        checks++; if (rgb_valid !== 1'b0) $display("[TB] FAIL reset_rgb_valid: got %b expected 0", rgb_valid); else passes++;
        checks++; if (pal_rd !== 1'b0) $display("[TB] FAIL reset_pal_rd: got %b expected 0", pal_rd); else passes++;
        checks++; if (rgb_data !== '0) $display("[TB] FAIL reset_rgb_data: got %h expected 0", rgb_data); else passes++;
        checks++; if (rgb_transparent !== 1'b0) $display("[TB] FAIL reset_transparent: got %b expected 0", rgb_transparent); else passes++;
        @(posedge clk);
        #1;
        reset_n = 1'b1; pix_valid = 1'b0;
        @(negedge clk);
        checks++; if (pix_ready !== 1'b1) $display("[TB] FAIL release_pix_ready: got %b expected 1", pix_ready); else passes++;
        checks++; if (rgb_valid !== 1'b0) $display("[TB] FAIL release_rgb_valid: got %b expected 0", rgb_valid); else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        logic acc, popped; exp_t obs, e; int outst;
        int idx = 0, pops = 0, first = -1, last = -1, gaps = 0;
        exp_q.delete();
        rgb_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && pops < 16; cyc++) begin
            pix_valid = (idx < 16);
            pix_index = 10'(idx);
            tick(acc, popped, obs, outst);
            if (acc) idx++;
            if (popped) begin
                if (first < 0) first = cyc;
                else if (cyc != last + 1) gaps++;
                last = cyc;
                pops++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL stream_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL stream_word: got %h/%b expected %h/%b", obs.word, obs.tr, e.word, e.tr);
                    else passes++;
                end
            end
        end
        pix_valid = 1'b0;
        checks++; if (first !== 2) $display("[TB] FAIL stream_latency: got cycle %0d expected 2", first); else passes++;
        checks++; if (gaps !== 0) $display("[TB] FAIL stream_gaps: got %0d expected 0", gaps); else passes++;
        checks++; if (pops !== 16) $display("[TB] FAIL stream_count: got %0d expected 16", pops); else passes++;
    endtask

    task automatic test_back_pressure();
        logic acc, popped; exp_t obs, e; int outst;
        int idx = 5, accs = 0, pops = 0;
        exp_q.delete();
        rgb_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            pix_valid = (idx <= 9);
            pix_index = 10'(idx);
            tick(acc, popped, obs, outst);
            if (acc) begin idx++; accs++; end
        end
        @(negedge clk);
        checks++; if (accs !== 4) $display("[TB] FAIL bp_accepts: got %0d expected 4", accs); else passes++;
        checks++; if (pix_ready !== 1'b0) $display("[TB] FAIL bp_pix_ready: got %b expected 0", pix_ready); else passes++;
        checks++; if (rgb_valid !== 1'b1) $display("[TB] FAIL bp_rgb_valid: got %b expected 1", rgb_valid); else passes++;
        checks++; if (rgb_data !== 24'h050607) $display("[TB] FAIL bp_hold_data: got %h expected 050607", rgb_data); else passes++;
        @(posedge clk);
        #1;
        rgb_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            pix_valid = (idx <= 9);
            pix_index = 10'(idx);
            tick(acc, popped, obs, outst);
            if (acc) idx++;
            if (popped) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL bp_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL bp_word: got %h expected %h", obs.word, e.word);
                    else passes++;
                end
            end
        end
        pix_valid = 1'b0;
        checks++; if (pops !== 5) $display("[TB] FAIL bp_delivered: got %0d expected 5", pops); else passes++;
    endtask

    task automatic test_random();
        logic acc, popped; exp_t obs, e; int outst, r;
        logic last_acc = 1'b1;
        exp_q.delete();
        pix_valid = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!pix_valid || last_acc) begin
                pix_valid = ($urandom_range(9, 0) < 7);
                r = $urandom_range(9, 0);
                pix_index = (r == 0) ? 10'd0 : (r == 1) ? 10'd1023 : 10'($urandom);
            end
            rgb_ready = ($urandom_range(9, 0) < 6);
            tick(acc, popped, obs, outst);
            last_acc = acc;
            checks++;
            if (acc !== (pix_valid && (outst < DEPTH)))
                $display("[TB] FAIL rand_accept: got %b expected %b (credits %0d)", acc, pix_valid && (outst < DEPTH), outst);
            else passes++;
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rand_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL rand_word: got %h/%b expected %h/%b", obs.word, obs.tr, e.word, e.tr);
                    else passes++;
                end
            end
        end
        pix_valid = 1'b0;
        rgb_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick(acc, popped, obs, outst);
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL rand_drain_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL rand_drain_word: got %h expected %h", obs.word, e.word);
                    else passes++;
                end
            end
        end
        checks++; if (exp_q.size() !== 0) $display("[TB] FAIL rand_lost: got %0d pending expected 0", exp_q.size()); else passes++;
    endtask

    task automatic test_reset_mid();
        logic acc, popped; exp_t obs, e; int outst;
        int pops = 0;
        exp_q.delete();
        rgb_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            pix_valid = 1'b1;
            pix_index = 10'(100 + n);
            tick(acc, popped, obs, outst);
        end
        // Three words queued, one read in flight.
        reset_n = 1'b0; pix_valid = 1'b1; pix_index = 10'd200;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++; if (rgb_valid !== 1'b0) $display("[TB] FAIL midrst_rgb_valid: got %b expected 0", rgb_valid); else passes++;
            checks++; if (pix_ready !== 1'b0) $display("[TB] FAIL midrst_pix_ready: got %b expected 0", pix_ready); else passes++;
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1; pix_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++; if (pix_ready !== 1'b1) $display("[TB] FAIL midrst_release_ready: got %b expected 1", pix_ready); else passes++;
        checks++; if (rgb_valid !== 1'b0) $display("[TB] FAIL midrst_release_valid: got %b expected 0", rgb_valid); else passes++;
        @(posedge clk);
        #1;
        rgb_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            pix_valid = (cyc == 0);
            pix_index = 10'd42;
            tick(acc, popped, obs, outst);
            if (popped) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL midrst_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs.word !== 24'h2a2b2c) $display("[TB] FAIL midrst_word: got %h expected 2a2b2c", obs.word);
                    else passes++;
                end
            end
        end
        pix_valid = 1'b0;
        checks++; if (pops !== 1) $display("[TB] FAIL midrst_count: got %0d expected 1", pops); else passes++;
    endtask

    task automatic test_full_push_pop();
        logic acc, popped; exp_t obs, e; int outst;
        int idx = 300, bad_tp = 0, bad_occ = 0;
        exp_q.delete();
        rgb_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            pix_valid = (cyc < 4);
            pix_index = 10'(idx);
            tick(acc, popped, obs, outst);
            if (acc) idx++;
        end
        @(negedge clk);
        checks++; if (pix_ready !== 1'b0) $display("[TB] FAIL full_pix_ready: got %b expected 0", pix_ready); else passes++;
        @(posedge clk);
        #1;
        rgb_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            pix_valid = 1'b1;
            pix_index = 10'(idx);
            tick(acc, popped, obs, outst);
            if (acc) idx++;
            if (!popped) bad_tp++;
            if (outst < 3 || outst > DEPTH) bad_occ++;
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL full_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL full_word: got %h expected %h", obs.word, e.word);
                    else passes++;
                end
            end
        end
        checks++; if (bad_tp !== 0) $display("[TB] FAIL full_throughput: got %0d idle cycles expected 0", bad_tp); else passes++;
        checks++; if (bad_occ !== 0) $display("[TB] FAIL full_occupancy: got %0d out-of-range cycles expected 0", bad_occ); else passes++;
        pix_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick(acc, popped, obs, outst);
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL full_drain_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL full_drain_word: got %h expected %h", obs.word, e.word);
                    else passes++;
                end
            end
        end
        checks++; if (exp_q.size() !== 0) $display("[TB] FAIL full_lost: got %0d pending expected 0", exp_q.size()); else passes++;
    endtask

`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
    task automatic test_transparency();
        logic acc, popped; exp_t obs, e; int outst;
        int n = 0, pops = 0;
        logic [2:0] tr_seen = 3'b000;
        logic [9:0] seq [3] = '{10'd0, 10'd1, 10'd0};
        exp_q.delete();
        rgb_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            pix_valid = (n < 3);
            pix_index = (n < 3) ? seq[n] : 10'd0;
            tick(acc, popped, obs, outst);
            if (acc) n++;
            if (popped) begin
                if (pops < 3) tr_seen[2 - pops] = obs.tr;
                pops++;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL tr_extra: got %h expected no word", obs.word);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("[TB] FAIL tr_word: got %h/%b expected %h/%b", obs.word, obs.tr, e.word, e.tr);
                    else passes++;
                end
            end
        end
        pix_valid = 1'b0;
        checks++; if (tr_seen !== 3'b101) $display("[TB] FAIL tr_flags: got %b expected 101", tr_seen); else passes++;
        checks++; if (pops !== 3) $display("[TB] FAIL tr_count: got %0d expected 3", pops); else passes++;
    endtask
`endif

    initial begin
        reset_n = 1'b0; pix_valid = 1'b0; pix_index = '0; rgb_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_random();
        test_reset_mid();
        test_full_push_pop();
`ifdef PALETTE_LOOKUP_TRANSPARENCY_EN
        test_transparency();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no completion expected finish");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/palette_lookup.md
Name: palette_lookup

Overview:
- Display-side reader of the palette RAM's port B.
- Accepts a stream of 10-bit colour indices from the renderer and issues reads on palette port B.
- Captures the 1-cycle-latency RAM data and delivers packed RGB words on a valid/ready stream to the video output stage.
- A small FIFO absorbs in-flight reads so downstream back-pressure never loses data.

Parameters:
- NUM_CHANNELS, 3, colour channels per entry; data width = NUM_CHANNELS*8.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ 2; ≥ 3 needed for one pixel per cycle.

Ports:
- clk  in  1  sole clock; also drives palette port B clock.
- reset_n  in  1  synchronous, active-low reset.
- pix_valid  in  1  index present.
- pix_ready  out  1  block accepts index this cycle.
- pix_index  in  10  palette index.
- pal_rd  out  1  port B read enable.
- pal_addr  out  10  port B address.
- pal_data  in  NUM_CHANNELS*8  port B q; valid one cycle after pal_rd.
- rgb_valid  out  1  output word present.
- rgb_ready  in  1  downstream accepts.
- rgb_data  out  NUM_CHANNELS*8  channel i in bits [8i+7:8i].
- rgb_transparent  out  1  only with the optional feature.

Behaviour:
- Accept: accept = pix_valid && pix_ready. pal_rd = accept; pal_addr = pix_index (combinational; RAM registers the address).
- Credits: credits = fifo_count + inflight, range 0..FIFO_DEPTH. pix_ready = (credits < FIFO_DEPTH). It is a function of registered state only; there is no combinational path from rgb_ready or pix_valid.
- In-flight: inflight register is set to accept each cycle. When inflight=1, pal_data is pushed into the FIFO at the end of that cycle.
- Pop: pop = rgb_valid && rgb_ready. rgb_valid = (fifo_count != 0). rgb_data = FIFO head, driven from a register.
- Credit update: +1 on accept, −1 on pop. Both together means no change.
- Latency: index accepted in cycle t gives pal_rd in t, pal_data in t+1, rgb_valid in t+2.
- Throughput: with FIFO_DEPTH ≥ 3 and rgb_ready held high, one word per cycle is sustained.
- Ordering: strict FIFO; output order equals input order.
- FIFO full:
  - The credit rule guarantees a push never finds the FIFO full.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty.
  - Push into an empty FIFO appears on rgb_data the next cycle; there is no bypass.
- Back-pressure: rgb_ready low holds rgb_data and rgb_valid stable until the word is popped.
- Read pointer wrap: modulo FIFO_DEPTH, correct for non-power-of-2 depths.
- Index range: all 1024 indices are legal; no range check.
- Reset values:
  - pix_ready=0 and rgb_valid=0 while reset_n=0.
  - pal_rd=0 during reset.
  - rgb_data=0; rgb_transparent=0.
- After reset:
  - Pointers, count and inflight are cleared.
  - pix_ready=1 the first cycle after reset_n rises.
- Reset mid-operation: in-flight reads and queued words are discarded. Any RAM data returning the cycle after reset is ignored.

Optional Feature:
- Macro: PALETTE_LOOKUP_TRANSPARENCY_EN.
- When defined:
  - Adds parameter TRANSPARENT_INDEX (default 0) and output rgb_transparent.
  - A flag (pix_index == TRANSPARENT_INDEX) is registered alongside inflight and stored as an extra FIFO bit.
  - rgb_transparent is valid with rgb_data.
  - The RAM is still read and its data forwarded unchanged.
- When undefined: no port, no parameter, no extra storage; behaviour otherwise identical.

Decomposition:
- Shared package palette_pkg:
  - BITS_PER_BYTE=8.
  - PALETTE_ADDR_WIDTH=10.
  - Default NUM_CHANNELS=3.
  - Packed rgb word typedef helper width function.
  - Shared with the Palette wrapper.
- Sub-module palette_lookup_fifo: synchronous FIFO with parameterised width/depth, push/pop, count, registered head output, synchronous active-low clear.

Test Plan:
- Streaming: indices 0..15 with pix_valid=1, rgb_ready=1, RAM model entry n = {n,n+1,n+2} → 16 words, first at cycle 2, one per cycle, exact order.
- Back-pressure:
  - Stream indices 5,6,7,8,9 with rgb_ready=0 → pix_ready drops after 4 accepts (FIFO_DEPTH=4).
  - rgb_data holds entry 5.
  - Raise rgb_ready → 5..9 delivered, none lost or duplicated.
- Random stalls: random pix_valid/rgb_ready (10k cycles, random indices incl. 0 and 1023) → scoreboard match. pal_rd never asserts when credits=FIFO_DEPTH.
- Reset mid-stream: assert reset_n=0 with 3 words queued and 1 in flight → next cycle rgb_valid=0 and pix_ready=0. After release, pix_ready=1 and the first new index 42 returns entry 42 only.
- Simultaneous push/pop at full: hold FIFO at 4, then rgb_ready=1 with continuous input → occupancy stays 3–4, throughput 1/cycle.
- Transparency (macro defined, TRANSPARENT_INDEX=0): indices 0,1,0 → rgb_transparent 1,0,1 with correct RAM data. With macro undefined the port is absent and the design compiles.
